mmio_arbiter: RTL and testbench
===============================

# mmio_arbiter

Two-master arbiter that shares the single MMIO bus (cs/read/write/21-bit word address/32-bit data) between the MicroBlaze MCS I/O bridge and a second bus master (debug/DMA port). Sequences each access with an explicit req/ack handshake and a configurable wait-state stretch for slow slaves. Sits between the masters and the MMIO slot decoder.

## Interface

- WAIT_CYCLES, 0, extra ACCESS cycles before read data is sampled (0..15)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  request; held high until the matching ack
- m0_write / m1_write  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  21  word address; stable while req high
- m0_wdata / m1_wdata  in  32  write data; stable while req high
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid in the ack cycle, held until the next ack to that master
- mmio_cs  out  1  bus select
- mmio_read / mmio_write  out  1  single-cycle strobes
- mmio_addr  out  21  granted address
- mmio_write_data  out  32  granted write data
- mmio_read_data  in  32  slave read data, combinational from addr/cs

## Operation

- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any req high, latch winner index, write flag, addr, wdata into registers; go ACCESS. Else stay.
- Arbitration: round-robin on a 1-bit last_grant register (reset value 1, so m0 wins the first tie). Only one req -> that master wins. Both -> master != last_grant wins; last_grant updated on every grant.
- ACCESS: wait counter loaded with WAIT_CYCLES on entry, decrements each ACCESS cycle. mmio_cs high for all ACCESS cycles; mmio_addr/mmio_write_data driven from latched registers. mmio_read or mmio_write (per latched flag) high only on the first ACCESS cycle. On the cycle counter == 0: for reads, capture mmio_read_data into the winner's rdata register; go ACK.
- ACK: winner's ack high for exactly this cycle; other ack low; go IDLE.
- Loser's req stays pending and is considered in the following IDLE cycle; no starvation (alternation guaranteed under continuous contention).
- Masters must keep req/write/addr/wdata stable until ack; arbiter latches at grant, so changes after grant are ignored. Req still high in the IDLE after ack is a new transaction.
- Writes do not modify rdata registers.
- mmio_addr/mmio_write_data are 0 when not in ACCESS.

## Timing

- Reset (async assert, sync-released by the system): state IDLE, last_grant = 1, counter 0, all outputs 0 (acks, strobes, cs, addr, write_data, both rdata).
- Reset mid-transaction: in-flight access aborted immediately, no ack issued, strobes drop asynchronously.
- Latency, req sampled high in IDLE at cycle N: ACCESS N+1 .. N+1+WAIT_CYCLES; strobe at N+1; ack at N+2+WAIT_CYCLES.
- Transaction period: 3 + WAIT_CYCLES cycles; back-to-back from one master: next strobe 3 + WAIT_CYCLES cycles after the previous one.
- Simultaneous new req and ack in the same cycle: req is only sampled in IDLE, so it is granted in the cycle after ACK.
- Counter is 4 bits; WAIT_CYCLES > 15 is illegal (elaboration assertion).

## Test plan

- Reset: assert reset_n=0 mid-ACCESS -> all outputs 0 same cycle; after release, state IDLE, no spurious ack.
- Single read, WAIT_CYCLES=0: m0 read addr 0x000010, slave returns 0xDEADBEEF -> mmio_read pulse at N+1 with mmio_addr 0x000010, m0_ack at N+2, m0_rdata=0xDEADBEEF.
- Single write from m1: addr 0x1FFFFF, wdata 0x12345678 -> one mmio_write pulse, mmio_write_data 0x12345678, m1_ack at N+2, m1_rdata unchanged.
- Contention: both req held for 4 transactions from reset -> grant order m0, m1, m0, m1; acks 3 cycles apart; never both acks high.
- Wait states, WAIT_CYCLES=3: m0 read -> mmio_cs high 4 cycles, mmio_read high only first cycle, data sampled on 4th cycle, ack at N+5.
- Stability: m0 changes addr after grant -> mmio_addr keeps latched value through ACCESS.

Source files
------------

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares one MMIO bus between two masters (m0 = MCS I/O bridge,
// m1 = debug/DMA port). Each access is latched at grant, held on the bus for
// 1 + WAIT_CYCLES cycles and completed with a one-cycle ack to the winner.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | bus free; sample requests, latch the winner's transaction
//   S_ACCESS | cs asserted, strobe on first cycle, count down wait states
//   S_ACK    | one-cycle ack pulse to the winner, then back to idle
module mmio_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        m0_req,
   input  logic        m0_write,
   input  logic [20:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic        m1_write,
   input  logic [20:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,

   output logic        mmio_cs,
   output logic        mmio_read,
   output logic        mmio_write,
   output logic [20:0] mmio_addr,
   output logic [31:0] mmio_write_data,
   input  logic [31:0] mmio_read_data
);

   // The wait counter is 4 bits wide, so larger stretches cannot be honoured.
   if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mmio_arbiter: WAIT_CYCLES must be in 0..15");
   end

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        win_q, win_d;
   logic        wr_q, wr_d;
   logic [20:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic        any_req;
   logic        pick;
   logic        in_access;
   logic        first_access;

   // Round-robin pick: a lone requester wins; on a tie the master that did not
   // win last time is chosen, so continuous contention alternates.
   always_comb begin
      any_req = m0_req | m1_req;
      pick    = (m0_req & m1_req) ? ~last_grant_q : m1_req;
   end

   // Next-state logic for the sequencer, counter and latched transaction.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      win_d        = win_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d      = S_ACCESS;
               cnt_d        = WAIT_LOAD;
               win_d        = pick;
               last_grant_d = pick;
               wr_d         = pick ? m1_write : m0_write;
               addr_d       = pick ? m1_addr  : m0_addr;
               wdata_d      = pick ? m1_wdata : m0_wdata;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               // Read data is taken on the last ACCESS cycle, after the slave
               // has had the full wait-state stretch to settle.
               if (!wr_q) begin
                  if (win_q) begin
                     rdata1_d = mmio_read_data;
                  end else begin
                     rdata0_d = mmio_read_data;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any in-flight access immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b1;
         win_q        <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= 21'd0;
         wdata_q      <= 32'd0;
         rdata0_q     <= 32'd0;
         rdata1_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // Bus outputs decode straight from registered state, so they fall in the
   // same cycle as an asynchronous reset. The counter still holds its load
   // value only on the first ACCESS cycle, which marks the strobe cycle.
   always_comb begin
      in_access       = (state_q == S_ACCESS);
      first_access    = in_access & (cnt_q == WAIT_LOAD);
      mmio_cs         = in_access;
      mmio_read       = first_access & ~wr_q;
      mmio_write      = first_access &  wr_q;
      mmio_addr       = in_access ? addr_q  : 21'd0;
      mmio_write_data = in_access ? wdata_q : 32'd0;
      m0_ack          = (state_q == S_ACK) & ~win_q;
      m1_ack          = (state_q == S_ACK) &  win_q;
      m0_rdata        = rdata0_q;
      m1_rdata        = rdata1_q;
   end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: two instances (no wait states, three wait states),
// a transaction-level reference model per instance, directed scenarios with
// literal expectations, then randomized traffic from both masters.
module tb_mmio_arbiter;

   logic        clk;
   logic        reset_n;

   logic        req   [2][2];
   logic        wr    [2][2];
   logic [20:0] addr  [2][2];
   logic [31:0] wdata [2][2];
   logic        ack   [2][2];
   logic [31:0] rdata [2][2];

   logic        cs    [2];
   logic        rd    [2];
   logic        wstb  [2];
   logic [20:0] maddr [2];
   logic [31:0] mwd   [2];
   logic [31:0] mrd   [2];

   int n_pass = 0;
   int n_tot  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] slave_f(input logic [20:0] a);
      if (a == 21'h000010) return 32'hDEADBEEF;
      return {a[10:0], a} ^ 32'h5A0F_C3E1;
   endfunction

   assign mrd[0] = cs[0] ? slave_f(maddr[0]) : 32'h0;
   assign mrd[1] = cs[1] ? slave_f(maddr[1]) : 32'h0;

   mmio_arbiter #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset_n(reset_n),
      .m0_req(req[0][0]), .m0_write(wr[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
      .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
      .m1_req(req[0][1]), .m1_write(wr[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
      .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
      .mmio_cs(cs[0]), .mmio_read(rd[0]), .mmio_write(wstb[0]),
      .mmio_addr(maddr[0]), .mmio_write_data(mwd[0]), .mmio_read_data(mrd[0])
   );

   mmio_arbiter #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset_n(reset_n),
      .m0_req(req[1][0]), .m0_write(wr[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
      .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
      .m1_req(req[1][1]), .m1_write(wr[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
      .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
      .mmio_cs(cs[1]), .mmio_read(rd[1]), .mmio_write(wstb[1]),
      .mmio_addr(maddr[1]), .mmio_write_data(mwd[1]), .mmio_read_data(mrd[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a granted transaction at cycle gc occupies the bus in
   // cycles gc+1 .. gc+1+W, acks at gc+2+W and frees the arbiter at gc+3+W.
   for (genvar g = 0; g < 2; g++) begin : g_model
      localparam int W = 3 * g;
      int          cyc;
      bit          busy;
      int          gc;
      int          win;
      int          lg;
      bit          gwr;
      logic [20:0] gaddr;
      logic [31:0] gwd;
      logic [31:0] erd [2];
      bit          e_cs;

      initial begin
         cyc = 0; busy = 0; gc = 0; win = 0; lg = 1; gwr = 0;
         gaddr = '0; gwd = '0; erd[0] = '0; erd[1] = '0;
         forever begin
            @(negedge clk);
            if (!reset_n) begin
               cyc = 0; busy = 0; lg = 1; erd[0] = '0; erd[1] = '0;
            end else begin
               if (busy && cyc >= gc + 3 + W) busy = 0;
               if (!busy && (req[g][0] || req[g][1])) begin
                  if (req[g][0] && req[g][1]) win = 1 - lg;
                  else win = req[g][0] ? 0 : 1;
                  lg    = win;
                  busy  = 1;
                  gc    = cyc;
                  gwr   = wr[g][win];
                  gaddr = addr[g][win];
                  gwd   = wdata[g][win];
               end
               e_cs = busy && (cyc >= gc + 1) && (cyc <= gc + 1 + W);
               if (busy && cyc == gc + 2 + W && !gwr) erd[win] = slave_f(gaddr);
               chk($sformatf("w%0d cs", W),      cs[g],   e_cs);
               chk($sformatf("w%0d read", W),    rd[g],   busy && cyc == gc + 1 && !gwr);
               chk($sformatf("w%0d write", W),   wstb[g], busy && cyc == gc + 1 && gwr);
               chk($sformatf("w%0d addr", W),    maddr[g], e_cs ? gaddr : 21'h0);
               chk($sformatf("w%0d wdata", W),   mwd[g],  e_cs ? gwd : 32'h0);
               chk($sformatf("w%0d m0_ack", W),  ack[g][0], busy && cyc == gc + 2 + W && win == 0);
               chk($sformatf("w%0d m1_ack", W),  ack[g][1], busy && cyc == gc + 2 + W && win == 1);
               chk($sformatf("w%0d m0_rdata", W), rdata[g][0], erd[0]);
               chk($sformatf("w%0d m1_rdata", W), rdata[g][1], erd[1]);
               cyc++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic seen [2][2];
   int   wcnt [2][2];
   int   maxw [2][2];
   int   nack;

   initial begin
      reset_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         for (int m = 0; m < 2; m++) begin
            req[g][m] = 0; wr[g][m] = 0; addr[g][m] = '0; wdata[g][m] = '0;
            seen[g][m] = 0; wcnt[g][m] = 0; maxw[g][m] = 0;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("reset cs", cs[g], 0);
         chk("reset m0_ack", ack[g][0], 0);
         chk("reset m1_ack", ack[g][1], 0);
         chk("reset m0_rdata", rdata[g][0], 0);
         chk("reset m1_rdata", rdata[g][1], 0);
      end
      reset_n = 1'b1;

      // Single read from m0, no wait states.
      step();
      req[0][0] = 1; wr[0][0] = 0; addr[0][0] = 21'h000010;
      step();
      chk("A read strobe", rd[0], 1);
      chk("A addr", maddr[0], 21'h000010);
      chk("A ack early", ack[0][0], 0);
      step();
      chk("A ack", ack[0][0], 1);
      chk("A rdata", rdata[0][0], 32'hDEADBEEF);
      req[0][0] = 0;

      // Single write from m1.
      step();
      req[0][1] = 1; wr[0][1] = 1; addr[0][1] = 21'h1FFFFF; wdata[0][1] = 32'h12345678;
      step();
      chk("B write strobe", wstb[0], 1);
      chk("B read strobe", rd[0], 0);
      chk("B wdata", mwd[0], 32'h12345678);
      chk("B addr", maddr[0], 21'h1FFFFF);
      step();
      chk("B ack", ack[0][1], 1);
      chk("B m1_rdata", rdata[0][1], 32'h0);
      req[0][1] = 0;

      // Continuous contention: m0, m1, m0, m1 with acks 3 cycles apart.
      step();
      req[0][0] = 1; wr[0][0] = 0; addr[0][0] = 21'h000200;
      req[0][1] = 1; wr[0][1] = 0; addr[0][1] = 21'h000300;
      nack = 0;
      for (int t = 1; t <= 20 && nack < 4; t++) begin
         step();
         chk("C exclusive ack", ack[0][0] & ack[0][1], 0);
         if (ack[0][0] || ack[0][1]) begin
            chk($sformatf("C grant %0d is m1", nack), ack[0][1], nack % 2);
            chk($sformatf("C ack time %0d", nack), t, 2 + 3 * nack);
            nack++;
            if (nack == 4) begin
               req[0][0] = 0; req[0][1] = 0;
            end
         end
      end
      chk("C ack count", nack, 4);

      // Three wait states, with m0 changing its address after grant.
      step();
      req[1][0] = 1; wr[1][0] = 0; addr[1][0] = 21'h000123;
      for (int t = 1; t <= 5; t++) begin
         step();
         chk($sformatf("D cs t%0d", t), cs[1], t <= 4);
         chk($sformatf("D read t%0d", t), rd[1], t == 1);
         chk($sformatf("D ack t%0d", t), ack[1][0], t == 5);
         if (t <= 4) chk($sformatf("D addr t%0d", t), maddr[1], 21'h000123);
         if (t == 1) addr[1][0] = 21'h000456;
      end
      chk("D rdata", rdata[1][0], slave_f(21'h000123));
      req[1][0] = 0;

      // Reset in the middle of an access on both instances.
      step();
      for (int g = 0; g < 2; g++) begin
         req[g][0] = 1; wr[g][0] = 0; addr[g][0] = 21'h000010;
      end
      step();
      chk("E strobe before reset", rd[0], 1);
      chk("E cs before reset", cs[1], 1);
      #2 reset_n = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("E cs", cs[g], 0);
         chk("E read", rd[g], 0);
         chk("E write", wstb[g], 0);
         chk("E addr", maddr[g], 0);
         chk("E wdata", mwd[g], 0);
         chk("E m0_ack", ack[g][0], 0);
         chk("E m1_ack", ack[g][1], 0);
         chk("E m0_rdata", rdata[g][0], 0);
         chk("E m1_rdata", rdata[g][1], 0);
         req[g][0] = 0;
      end
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         step();
         for (int g = 0; g < 2; g++) begin
            chk("E no spurious m0_ack", ack[g][0], 0);
            chk("E no spurious m1_ack", ack[g][1], 0);
         end
      end

      // Randomized traffic on both masters of both instances.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) seen[g][m] = ack[g][m];
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            for (int m = 0; m < 2; m++) begin
               if (req[g][m] && !seen[g][m]) begin
                  wcnt[g][m]++;
                  if (wcnt[g][m] > maxw[g][m]) maxw[g][m] = wcnt[g][m];
               end else if ((req[g][m] && $urandom_range(1, 0) == 1) ||
                            (!req[g][m] && $urandom_range(2, 0) == 0)) begin
                  req[g][m]   = 1;
                  wr[g][m]    = 1'($urandom_range(1, 0));
                  addr[g][m]  = ($urandom_range(7, 0) == 0) ? 21'h000010 : 21'($urandom);
                  wdata[g][m] = $urandom;
                  wcnt[g][m]  = 0;
               end else begin
                  req[g][m]  = 0;
                  wcnt[g][m] = 0;
               end
            end
         end
      end
      for (int g = 0; g < 2; g++)
         for (int m = 0; m < 2; m++)
            chk($sformatf("R wait bound w%0d m%0d", 3 * g, m),
                maxw[g][m] <= 2 * (3 + 3 * g) + 2, 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
